// File: rtl/bram_request_adapter.sv
// bram_request_adapter: one-at-a-time load/store front end for a single registered-read BRAM
// Ports: clock/reset (async, active-high); req_* valid/ready request from the core (byte address,
// byte enables, store data); resp_* one-cycle response pulse with load data and misalignment error;
// bram_* read/write ports to the BRAM (1-cycle read latency); scan enables a cycle-windowed trace.
module bram_request_adapter #(
  parameter int CORE = 0,
  parameter int ADDR_WIDTH = 8,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [3:0]            req_byte_en,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  bram_read_enable,
  output logic [ADDR_WIDTH-1:0] bram_read_address,
  input  logic [31:0]           bram_read_data,
  output logic                  bram_write_enable,
  output logic [ADDR_WIDTH-1:0] bram_write_address,
  output logic [31:0]           bram_write_data,
  input  logic                  scan
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_MERGE, RESP} state_t;
  state_t state_q, state_d;
  logic write_q, write_d, err_q, err_d, misaligned;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, waddr;
  logic [3:0] be_q, be_d;
  logic [31:0] wdata_q, wdata_d, merged;
  int cycle_q, cycle_d;
  assign waddr = req_addr[ADDR_WIDTH+1:2];
  assign misaligned = |req_addr[1:0];
  assign req_ready = state_q == IDLE;
  assign cycle_d = cycle_q + 1;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : bram_read_data[8*i +: 8];
  end
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    err_d = err_q;
    addr_d = addr_q;
    be_d = be_q;
    wdata_d = wdata_q;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_error = 1'b0;
    bram_read_enable = 1'b0;
    bram_read_address = '0;
    bram_write_enable = 1'b0;
    bram_write_address = '0;
    bram_write_data = '0;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        err_d = misaligned;
        addr_d = waddr;
        be_d = req_byte_en;
        wdata_d = req_wdata;
        if (misaligned || (req_write && (req_byte_en == 4'h0 || req_byte_en == 4'hF))) begin
          state_d = RESP;
          bram_write_enable = !misaligned && req_byte_en == 4'hF;
          bram_write_address = bram_write_enable ? waddr : '0;
          bram_write_data = bram_write_enable ? req_wdata : '0;
        end else begin
          state_d = req_write ? RMW_MERGE : LOAD_WAIT;
          bram_read_enable = 1'b1;
          bram_read_address = waddr;
        end
      end
      LOAD_WAIT: begin
        state_d = IDLE;
        resp_valid = 1'b1;
        resp_rdata = bram_read_data;
      end
      RMW_MERGE: begin
        state_d = IDLE;
        resp_valid = 1'b1;
        bram_write_enable = 1'b1;
        bram_write_address = addr_q;
        bram_write_data = merged;
      end
      default: begin
        state_d = IDLE;
        resp_valid = 1'b1;
        resp_error = err_q;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      cycle_q <= 0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      err_q <= err_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      cycle_q <= cycle_d;
    end
  end
`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset && scan && cycle_q >= SCAN_CYCLES_MIN && cycle_q <= SCAN_CYCLES_MAX)
      $display("core%0d cyc%0d %s req v%b w%b a%h be%h d%h | lat w%b a%h be%h d%h e%b | rd e%b a%h d%h wr e%b a%h d%h",
        CORE, cycle_q, state_q.name(), req_valid, req_write, req_addr, req_byte_en, req_wdata,
        write_q, addr_q, be_q, wdata_q, err_q, bram_read_enable, bram_read_address, bram_read_data,
        bram_write_enable, bram_write_address, bram_write_data);
  end
`endif
endmodule

// File: tb/tb_bram_request_adapter.sv
// tb_bram_request_adapter: random and directed stimulus checked against a transaction-level model
module tb_bram_request_adapter;
  localparam int AW = 8;
  logic clock = 0, reset = 1;
  logic req_valid = 0, req_ready, req_write = 0, resp_valid, resp_error;
  logic [AW+1:0] req_addr = '0;
  logic [3:0] req_byte_en = '0;
  logic [31:0] req_wdata = '0, resp_rdata, bram_read_data, bram_write_data;
  logic bram_read_enable, bram_write_enable;
  logic [AW-1:0] bram_read_address, bram_write_address;
  always #5 clock = ~clock;
  bram_request_adapter #(.CORE(0), .ADDR_WIDTH(AW), .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_byte_en(req_byte_en), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .bram_read_enable(bram_read_enable),
    .bram_read_address(bram_read_address), .bram_read_data(bram_read_data),
    .bram_write_enable(bram_write_enable), .bram_write_address(bram_write_address),
    .bram_write_data(bram_write_data), .scan(1'b0));

  // BRAM environment: registered read with same-address write bypass
  logic [31:0] mem [256];
  logic [31:0] rd_q = '0;
  int wr_cnt = 0;
  assign bram_read_data = rd_q;
  always @(posedge clock) begin
    if (bram_read_enable)
      rd_q <= (bram_write_enable && bram_write_address == bram_read_address) ? bram_write_data : mem[bram_read_address];
    if (bram_write_enable) begin
      mem[bram_write_address] <= bram_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Transaction-level model: each accepted request owns the following cycle, in which its
  // response appears; a partial store's merged write lands in that same following cycle.
  logic [31:0] shadow [256];
  bit pend = 0, pend_rmw = 0, pend_err = 0;
  logic [31:0] pend_data, pend_wdata;
  logic [AW-1:0] pend_addr;
  logic [3:0] pend_be;
  int resp_seen = 0;
  always @(negedge clock) begin
    if (reset) begin
      pend = 0;
      pend_rmw = 0;
    end else begin
      automatic bit acc = req_valid && !pend;
      automatic bit al = req_addr[1:0] == 2'b00;
      automatic logic [AW-1:0] wa = req_addr[AW+1:2];
      automatic bit full = acc && al && req_write && req_byte_en == 4'hF;
      automatic bit exp_re = acc && al && (!req_write || (req_byte_en != 4'h0 && req_byte_en != 4'hF));
      automatic logic [31:0] mrg = pend_rmw ? merge(shadow[pend_addr], pend_wdata, pend_be) : 32'h0;
      chk("req_ready", {31'b0, req_ready}, {31'b0, !pend});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, pend});
      if (pend) begin
        chk("resp_rdata", resp_rdata, pend_data);
        chk("resp_error", {31'b0, resp_error}, {31'b0, pend_err});
        resp_seen++;
      end
      chk("read_enable", {31'b0, bram_read_enable}, {31'b0, exp_re});
      chk("read_address", {24'b0, bram_read_address}, exp_re ? {24'b0, wa} : 32'h0);
      chk("write_enable", {31'b0, bram_write_enable}, {31'b0, full || pend_rmw});
      chk("write_address", {24'b0, bram_write_address}, full ? {24'b0, wa} : pend_rmw ? {24'b0, pend_addr} : 32'h0);
      chk("write_data", bram_write_data, full ? req_wdata : mrg);
      if (pend_rmw) shadow[pend_addr] = mrg;
      pend = 0;
      pend_rmw = 0;
      if (acc) begin
        pend = 1;
        pend_err = !al;
        pend_data = (al && !req_write) ? shadow[wa] : 32'h0;
        pend_rmw = exp_re && req_write;
        pend_addr = wa;
        pend_be = req_byte_en;
        pend_wdata = req_wdata;
        if (full) shadow[wa] = req_wdata;
      end
    end
  end

  task automatic send(input logic w, input logic [AW+1:0] a, input logic [3:0] be, input logic [31:0] d);
    bit acc = 0;
    req_valid = 1; req_write = w; req_addr = a; req_byte_en = be; req_wdata = d;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clock) acc = req_ready;
      @(posedge clock) #1;
    end
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
    req_valid = 0;
  endtask
  task automatic get_resp(output logic [31:0] d, output logic e);
    int n = 0;
    d = 'x; e = 'x;
    while (n < 5) begin
      @(negedge clock);
      if (resp_valid) break;
      n++;
    end
    chk("resp_latency", n, 0);
    d = resp_rdata; e = resp_error;
  endtask

  initial begin
    logic [31:0] d, keep;
    logic e;
    int w0, r0, bad;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    mem[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;
    mem[3] = 32'h11223344; shadow[3] = 32'h11223344;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("reset_read_en", {31'b0, bram_read_enable}, 32'h0);
    chk("reset_write_en", {31'b0, bram_write_enable}, 32'h0);
    @(posedge clock) #1 reset = 0;
    @(negedge clock) chk("ready_after_reset", {31'b0, req_ready}, 32'h1);
    @(posedge clock) #1;
    send(0, 10'h010, 4'h0, 32'h0); get_resp(d, e);
    chk("load_deadbeef", d, 32'hDEADBEEF);
    chk("load_err", {31'b0, e}, 32'h0);
    send(1, 10'h008, 4'hF, 32'hCAFEF00D); get_resp(d, e);
    chk("store_rdata", d, 32'h0);
    @(posedge clock) #1;
    send(0, 10'h008, 4'h0, 32'h0); get_resp(d, e);
    chk("load_cafef00d", d, 32'hCAFEF00D);
    @(posedge clock) #1;
    w0 = wr_cnt;
    send(1, 10'h00C, 4'h6, 32'hAABBCCDD); get_resp(d, e);
    @(posedge clock) #1;
    chk("rmw_word", mem[3], 32'h11BBCC44);
    chk("rmw_single_write", wr_cnt - w0, 1);
    send(0, 10'h00E, 4'h0, 32'h0); get_resp(d, e);
    chk("misaligned_err", {31'b0, e}, 32'h1);
    chk("misaligned_rdata", d, 32'h0);
    @(posedge clock) #1;
    w0 = wr_cnt;
    send(1, 10'h020, 4'h0, 32'h12345678); get_resp(d, e);
    @(posedge clock) #1;
    chk("empty_store_no_write", wr_cnt - w0, 0);
    chk("empty_store_err", {31'b0, e}, 32'h0);
    r0 = resp_seen;
    send(0, 10'h010, 4'h0, 32'h0);
    send(0, 10'h008, 4'h0, 32'h0);
    send(0, 10'h00C, 4'h0, 32'h0);
    repeat (3) @(negedge clock);
    chk("b2b_responses", resp_seen - r0, 3);
    @(posedge clock) #1;
    keep = mem[9];
    send(1, 10'h024, 4'h3, 32'h99887766);
    chk("rmw_we_before_reset", {31'b0, bram_write_enable}, 32'h1);
    reset = 1;
    #1 chk("rmw_we_dropped", {31'b0, bram_write_enable}, 32'h0);
    chk("rmw_no_resp", {31'b0, resp_valid}, 32'h0);
    r0 = resp_seen;
    @(posedge clock) #1 reset = 0;
    @(negedge clock);
    chk("ready_after_rmw_reset", {31'b0, req_ready}, 32'h1);
    chk("dropped_no_resp", resp_seen - r0, 0);
    chk("rmw_target_unchanged", mem[9], keep);
    @(posedge clock) #1;
    for (int k = 0; k < 400; k++) begin
      automatic logic [3:0] be = $urandom_range(0, 3) == 0 ? 4'hF : $urandom_range(0, 5) == 0 ? 4'h0 : 4'($urandom);
      automatic logic [1:0] lo = $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 3) == 0) @(posedge clock) #1;
      send(1'($urandom), {6'($urandom_range(0, 15)), 2'b00, lo} == 0 ? 10'h0 : {2'b00, 4'($urandom_range(0, 15)), 2'b00, lo} | 10'h0, be, $urandom);
    end
    repeat (4) @(negedge clock);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) bad++;
    chk("final_memory", bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
